// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer with valid/ready on every channel.
// Routes by in_sel or by an internal round-robin pointer.
module demux_stream_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    auto_mode,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic                    err_sel
);

  logic [SEL_W-1:0]  tgt;
  logic [N_OUT-1:0]  hit;
  logic [N_OUT-1:0]  load;
  logic              tgt_ok;
  logic              accept;
  logic [SEL_W-1:0]  rr_next;
  logic [DATA_W-1:0] data_q [N_OUT];

  assign tgt = auto_mode ? rr_ptr : in_sel;

  // one-hot decode; an all-zero result means the target is out of range
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (tgt == SEL_W'(i)) hit[i] = 1'b1;
    end
  end

  assign tgt_ok   = |hit;
  assign in_ready = !tgt_ok || (|(hit & (~out_valid | out_ready)));
  assign accept   = in_valid && in_ready;
  assign load     = hit & {N_OUT{accept}};

  assign rr_next = (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + 1'b1;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      out_data[i*DATA_W +: DATA_W] = data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      rr_ptr    <= '0;
      err_sel   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) data_q[i] <= '0;
    end else begin
      err_sel <= accept && !tgt_ok;
      if (accept && auto_mode) rr_ptr <= rr_next;
      for (int i = 0; i < N_OUT; i++) begin
        if (load[i]) begin
          data_q[i]    <= in_data;
          out_valid[i] <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/demux_stream_n.md
Name: demux_stream_n

Overview:
- Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on the input and on every output channel.
- Routes each accepted input word to one of N_OUT channel registers. The channel is chosen either directly by in_sel or by an internal round-robin pointer (auto mode).
- Used wherever a single producer stream fans out to several consumers that can stall independently.

Parameters:
- DATA_W, 8, width of the data word.
- N_OUT, 8, number of output channels (2..16).
- SEL_W, 3, select/pointer width; must satisfy 2^SEL_W >= N_OUT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  DATA_W  input word.
- in_sel  input  SEL_W  target channel index; used only when auto_mode=0.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the word this cycle.
- auto_mode  input  1  1 = round-robin routing, 0 = in_sel routing.
- out_data  output  N_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid  output  N_OUT  channel i holds an undelivered word.
- out_ready  input  N_OUT  consumer i takes its word this cycle.
- rr_ptr  output  SEL_W  next round-robin target.
- err_sel  output  1  one-cycle pulse: a word was dropped due to an out-of-range in_sel.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, rr_ptr=0, err_sel=0. Any words held at assertion are discarded. Outputs hold these values while rst=1.
- Target t = auto_mode ? rr_ptr : in_sel.
- in_ready is combinational:
  - t < N_OUT: in_ready = !out_valid[t] | out_ready[t].
  - t >= N_OUT: in_ready = 1.
  - in_ready never depends on in_valid.
- Accept = in_valid & in_ready, sampled at the rising edge.
- Load, on accept with t < N_OUT: out_data[t] <= in_data and out_valid[t] <= 1. The word is visible the cycle after accept (latency 1).
- Drain: out_valid[i] & out_ready[i] with no load to channel i in the same cycle -> out_valid[i] <= 0. out_data[i] holds its last value.
- Simultaneous drain and load on the same channel: new word loaded, out_valid stays 1. This gives full throughput of 1 word/cycle per channel.
- Channel i not loaded and not drained: out_data[i] and out_valid[i] hold.
- Out-of-range select (auto_mode=0, in_sel >= N_OUT, in_valid=1):
  - Word accepted and dropped; no channel is touched.
  - err_sel=1 for exactly the next cycle, otherwise 0.
  - Back-to-back bad selects keep err_sel high, one cycle per dropped word.
- Round-robin pointer:
  - On accept with auto_mode=1, rr_ptr <= (rr_ptr == N_OUT-1) ? 0 : rr_ptr+1.
  - No accept: rr_ptr holds. A stalled target channel blocks the stream; the pointer does not skip ahead.
  - auto_mode=0: rr_ptr holds. Switching mode does not reset it, so auto routing resumes from the stored value.
  - In auto mode in_sel is ignored and err_sel cannot fire.
- out_ready on a channel with out_valid=0 has no effect.
- Only one channel can load per cycle. All other channels may drain concurrently in the same cycle.

Test Plan:
1. Reset, then auto_mode=0, in_sel=5, in_data=0xA7, in_valid=1 for 1 cycle, all out_ready=0 -> next cycle out_valid=8'b0010_0000 and channel 5 data=0xA7; all other channel data stay 0x00.
2. Backpressure: channel 2 full with 0x11, out_ready[2]=0, present in_sel=2, data=0x22 -> in_ready=0 and 0x11 held. Raise out_ready[2] -> same edge accepts 0x22, out_valid[2] stays 1, channel 2 data=0x22.
3. Round robin: auto_mode=1, all out_ready=1, send 10 words 0..9 back-to-back -> words land on channels 0,1,...,7,0,1; rr_ptr ends at 2; in_ready=1 throughout.
4. Out of range: N_OUT=6, SEL_W=3, in_sel=7, data=0x55 -> accepted, err_sel=1 for one cycle, out_valid unchanged, no channel data changes.
5. Mode switch: auto mode, 3 words accepted (rr_ptr=3); switch to auto_mode=0 and send 2 words via in_sel=0 -> rr_ptr stays 3. Return to auto mode -> next word lands on channel 3.
6. Reset mid-operation: with out_valid=8'hFF and rr_ptr=4, assert rst asynchronously between clock edges -> out_valid=0, out_data=0, rr_ptr=0 immediately. After release, the first word in auto mode lands on channel 0.
